// File: rtl/cic_interp_pdm_tx.sv
// PCM-to-PDM transmit path: 4th-order CIC interpolator (time-multiplexed combs,
// tick-driven integrators) followed by a 1st-order sigma-delta modulator.
module cic_interp_pdm_tx #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 48
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [9:0]        rate_i,
    input  logic [5:0]        shift_i,
    input  logic              pdm_tick_i,
    input  logic [DATA_W-1:0] pcm_data_i,
    input  logic              pcm_valid_i,
    output logic              pcm_ready_o,
    output logic              pdm_o,
    output logic              underrun_o
);

    localparam int unsigned RATE_W = 10;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned NSTG   = 4;
    localparam int unsigned HI_W   = ACC_W - DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMB = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic        [SEL_W-1:0]   r_sel;
    logic        [RATE_W-1:0]  r_rate;
    logic        [RATE_W-1:0]  r_phase;
    logic signed [ACC_W-1:0]   r_x;
    logic signed [ACC_W-1:0]   r_prev [NSTG];
    logic signed [ACC_W-1:0]   r_frame;
    logic signed [ACC_W-1:0]   r_int0, r_int1, r_int2, r_int3;
    logic        [DATA_W-1:0]  r_sd;
    logic                      r_pdm;
    logic                      r_underrun;

    logic                      w_accept;
    logic                      w_tick;
    logic                      w_boundary;
    logic                      w_comb_step;
    logic                      w_comb_last;
    logic                      w_take;
    logic signed [ACC_W-1:0]   w_diff;
    logic signed [ACC_W-1:0]   w_u;
    logic signed [ACC_W-1:0]   w_i0, w_i1, w_i2, w_i3;
    logic signed [ACC_W-1:0]   w_shifted;
    logic        [HI_W-1:0]    w_hi;
    logic                      w_fits;
    logic        [DATA_W-1:0]  w_y;
    logic        [DATA_W-1:0]  w_v;
    logic        [DATA_W:0]    w_sd_sum;

    assign pcm_ready_o = en_i & (r_state == ST_IDLE);
    assign pdm_o       = r_pdm;
    assign underrun_o  = r_underrun;

    assign w_accept    = pcm_valid_i & pcm_ready_o;
    assign w_tick      = en_i & pdm_tick_i;
    assign w_boundary  = w_tick & (r_phase == '0);
    assign w_comb_step = en_i & (r_state == ST_COMB);
    assign w_comb_last = w_comb_step & (r_sel == SEL_W'(NSTG - 1));
    assign w_take      = w_boundary & (r_state == ST_FULL);

    // Shared comb subtractor, one stage per enabled clock
    assign w_diff = r_x - r_prev[r_sel];

    // Zero-stuffed integrator cascade, all four updated in the same tick
    assign w_u  = w_take ? r_frame : '0;
    assign w_i0 = r_int0 + w_u;
    assign w_i1 = r_int1 + w_i0;
    assign w_i2 = r_int2 + w_i1;
    assign w_i3 = r_int3 + w_i2;

    // Gain shift and saturation to signed DATA_W, then offset-binary for the modulator
    assign w_shifted = w_i3 >>> shift_i;
    assign w_hi      = w_shifted[ACC_W-1:DATA_W-1];
    assign w_fits    = (w_hi == '0) || (w_hi == '1);
    assign w_y       = w_fits ? w_shifted[DATA_W-1:0]
                     : (w_shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                           : {1'b0, {(DATA_W-1){1'b1}}});
    assign w_v       = {~w_y[DATA_W-1], w_y[DATA_W-2:0]};
    assign w_sd_sum  = {1'b0, r_sd} + {1'b0, w_v};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept)    w_state_nxt = ST_COMB;
                ST_COMB: if (w_comb_last) w_state_nxt = ST_FULL;
                ST_FULL: if (w_take)      w_state_nxt = ST_IDLE;
                default:                  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rate     <= '0;
            r_sel      <= '0;
            r_phase    <= '0;
            r_x        <= '0;
            r_frame    <= '0;
            r_int0     <= '0;
            r_int1     <= '0;
            r_int2     <= '0;
            r_int3     <= '0;
            r_sd       <= '0;
            r_pdm      <= 1'b0;
            r_underrun <= 1'b0;
            for (int s = 0; s < NSTG; s++) r_prev[s] <= '0;
        end else if (clr_i) begin
            r_rate     <= rate_i;
            r_sel      <= '0;
            r_phase    <= '0;
            r_x        <= '0;
            r_frame    <= '0;
            r_int0     <= '0;
            r_int1     <= '0;
            r_int2     <= '0;
            r_int3     <= '0;
            r_sd       <= '0;
            r_pdm      <= 1'b0;
            r_underrun <= 1'b0;
            for (int s = 0; s < NSTG; s++) r_prev[s] <= '0;
        end else begin
            if (w_accept) begin
                r_x   <= ACC_W'($signed(pcm_data_i));
                r_sel <= '0;
            end else if (w_comb_step) begin
                r_prev[r_sel] <= r_x;
                r_x           <= w_diff;
                r_sel         <= r_sel + SEL_W'(1);
                if (w_comb_last) r_frame <= w_diff;
            end
            if (w_tick) begin
                r_phase <= (r_phase == r_rate) ? '0 : r_phase + RATE_W'(1);
                r_int0  <= w_i0;
                r_int1  <= w_i1;
                r_int2  <= w_i2;
                r_int3  <= w_i3;
                r_sd    <= w_sd_sum[DATA_W-1:0];
                r_pdm   <= w_sd_sum[DATA_W];
                if (w_boundary && (r_state != ST_FULL)) r_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cic_interp_pdm_tx.sv
// Randomized scoreboard bench for cic_interp_pdm_tx: a transfer-function model
// (4th difference, cumulative sums, density accumulator) predicts every PDM bit.
module tb_cic_interp_pdm_tx;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 48;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              en_i = 1'b0;
    logic              clr_i = 1'b0;
    logic [9:0]        rate_i = '0;
    logic [5:0]        shift_i = '0;
    logic              pdm_tick_i = 1'b0;
    logic [DATA_W-1:0] pcm_data_i = '0;
    logic              pcm_valid_i = 1'b0;
    logic              pcm_ready_o;
    logic              pdm_o;
    logic              underrun_o;

    cic_interp_pdm_tx #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .clr_i      (clr_i),
        .rate_i     (rate_i),
        .shift_i    (shift_i),
        .pdm_tick_i (pdm_tick_i),
        .pcm_data_i (pcm_data_i),
        .pcm_valid_i(pcm_valid_i),
        .pcm_ready_o(pcm_ready_o),
        .pdm_o      (pdm_o),
        .underrun_o (underrun_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit exp_q[$];
    bit act_bits[$];

    // reference model state
    logic signed [ACC_W-1:0] m_hist [4];
    logic signed [ACC_W-1:0] m_int  [4];
    logic signed [ACC_W-1:0] m_frame;
    bit                      m_have;
    bit                      m_under;
    int                      m_R;
    int                      m_shift;
    int                      m_k;
    longint                  m_sd;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int R, input int sh);
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = '0;
            m_int[i]  = '0;
        end
        m_frame = '0;
        m_have  = 1'b0;
        m_under = 1'b0;
        m_R     = R;
        m_shift = sh;
        m_k     = 0;
        m_sd    = 0;
    endtask

    // comb cascade == (1 - z^-1)^4 applied to the sample stream
    task automatic model_accept(input logic [DATA_W-1:0] d);
        logic signed [ACC_W-1:0] x;
        x = ACC_W'($signed(d));
        m_frame = x - 4 * m_hist[0] + 6 * m_hist[1] - 4 * m_hist[2] + m_hist[3];
        m_hist[3] = m_hist[2];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = x;
        m_have = 1'b1;
    endtask

    task automatic model_tick(output bit b);
        logic signed [ACC_W-1:0] u;
        logic signed [ACC_W-1:0] sh;
        longint y;
        longint sum;
        u = '0;
        if ((m_k % m_R) == 0) begin
            if (m_have) u = m_frame;
            else        m_under = 1'b1;
            m_have = 1'b0;
        end
        m_k++;
        m_int[0] = m_int[0] + u;
        m_int[1] = m_int[1] + m_int[0];
        m_int[2] = m_int[2] + m_int[1];
        m_int[3] = m_int[3] + m_int[2];
        sh = m_int[3] >>> m_shift;
        y  = longint'(sh);
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        sum = m_sd + y + 32768;
        b = (sum >= 65536);
        m_sd = b ? sum - 65536 : sum;
    endtask

    // monitor: every enabled tick yields one PDM bit to compare
    initial begin
        bit e;
        forever begin
            @(posedge clk);
            if (!rst_i && en_i && pdm_tick_i && !clr_i) begin
                @(negedge clk);
                act_bits.push_back(pdm_o);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pdm_unexpected_tick: got %0b with empty queue at %0t", pdm_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (pdm_o !== e) begin
                        failures++;
                        $display("FAIL pdm_bit: got %0b expected %0b at %0t", pdm_o, e, $time);
                    end
                end
            end
        end
    end

    task automatic do_clr(input int rate, input int sh);
        @(negedge clk);
        clr_i   = 1'b1;
        rate_i  = 10'(rate);
        shift_i = 6'(sh);
        @(negedge clk);
        clr_i = 1'b0;
        model_reset(rate + 1, sh);
    endtask

    task automatic feed(input logic [DATA_W-1:0] d, input int en_gap);
        int n;
        n = 0;
        pcm_valid_i = 1'b1;
        pcm_data_i  = d;
        while (!pcm_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: ready stayed 0 for %0d cycles", n);
        end
        @(negedge clk);
        pcm_valid_i = 1'b0;
        model_accept(d);
        if (en_gap > 0) begin
            en_i = 1'b0;
            repeat (en_gap) @(negedge clk);
            en_i = 1'b1;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic tick();
        bit b;
        pdm_tick_i = 1'b1;
        model_tick(b);
        exp_q.push_back(b);
        @(negedge clk);
        pdm_tick_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_frames(input int nf, input bit fixed, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] s;
        for (int f = 0; f < nf; f++) begin
            s = fixed ? d : DATA_W'($urandom);
            feed(s, 0);
            repeat (m_R) tick();
        end
    endtask

    function automatic int count_ones(input int from, input int len);
        int c;
        c = 0;
        for (int i = from; i < from + len; i++) c += int'(act_bits[i]);
        return c;
    endfunction

    initial begin
        int ones;
        // 1. reset
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_pdm", pdm_o, 0);
        chk("reset_underrun", underrun_o, 0);
        chk("reset_ready_en0", pcm_ready_o, 0);
        en_i = 1'b1;
        @(negedge clk);
        chk("reset_ready_en1", pcm_ready_o, 1);

        // 2. zero input gives 0,1,0,1,...
        do_clr(3, 6);
        act_bits.delete();
        run_frames(3, 1'b1, 16'h0000);
        for (int i = 0; i < 8; i++) chk("zero_pattern", act_bits[i], i % 2);

        // 3. DC 0x4000 -> 3/4 density
        do_clr(3, 6);
        act_bits.delete();
        run_frames(20, 1'b1, 16'h4000);
        ones = count_ones(16, 64);
        checks++;
        if (ones < 47 || ones > 49) begin
            failures++;
            $display("FAIL dc_density: got %0d ones expected 48+/-1", ones);
        end
        chk("dc_underrun", underrun_o, 0);

        // 4. saturation
        do_clr(3, 0);
        act_bits.delete();
        run_frames(20, 1'b1, 16'h7FFF);
        ones = count_ones(16, 64);
        checks++;
        if (ones < 63) begin
            failures++;
            $display("FAIL sat_density: got %0d ones expected >=63", ones);
        end

        // 5. underrun
        do_clr(3, 6);
        chk("underrun_before", underrun_o, 0);
        tick();
        chk("underrun_boundary", underrun_o, 1);
        repeat (4) tick();
        chk("underrun_sticky", underrun_o, 1);
        run_frames(1, 1'b1, 16'h1234);
        chk("underrun_still", underrun_o, 1);
        do_clr(3, 6);
        chk("underrun_clr", underrun_o, 0);

        // 6. clear mid-comb discards the pending sample
        pcm_valid_i = 1'b1;
        pcm_data_i  = 16'h5A5A;
        @(negedge clk);
        pcm_valid_i = 1'b0;
        @(negedge clk);
        chk("clr_mid_ready_busy", pcm_ready_o, 0);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        chk("clr_mid_ready", pcm_ready_o, 1);
        model_reset(4, 6);
        act_bits.delete();
        run_frames(2, 1'b1, 16'h0000);
        for (int i = 0; i < 8; i++) chk("clr_zero_pattern", act_bits[i], i % 2);

        // 7. randomized rates, shifts, samples, enable pauses and missed frames
        for (int it = 0; it < 12; it++) begin
            int r;
            int sh;
            r  = int'($urandom_range(0, 7));
            sh = int'($urandom_range(0, 14));
            do_clr(r, sh);
            rate_i = 10'($urandom_range(0, 1023));
            for (int f = 0; f < 6; f++) begin
                if ($urandom_range(0, 5) != 0)
                    feed(DATA_W'($urandom), int'($urandom_range(0, 3)));
                repeat (m_R) tick();
            end
            chk("rand_underrun", underrun_o, longint'(m_under));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
